// File: rtl/noc_rx_dispatch.sv
// Receive-side NoC endpoint: buffers router packets in order and dispatches the FIFO head
// to the divergence slot, the clause slot or the per-core status table, or drops it.
module noc_rx_dispatch #(
  parameter int FIFO_DEPTH     = 4,
  parameter int MY_ID          = 0,
  parameter int LBD_ACCEPT_MAX = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [79:0] pkt_data,
  output logic        div_valid,
  input  logic        div_ready,
  output logic [31:0] div_lit,
  output logic [3:0]  div_src,
  output logic        cls_valid,
  input  logic        cls_ready,
  output logic [31:0] cls_lit0,
  output logic [31:0] cls_lit1,
  output logic [7:0]  cls_lbd,
  output logic [3:0]  cls_src,
  output logic [31:0] status_table,
  output logic        any_sat,
  output logic        any_unsat,
  output logic [15:0] drop_cnt,
  output logic        err_bad_type
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       MY_ID_C   = 4'(MY_ID);
  localparam logic [7:0]       LBD_MAX_C = 8'(LBD_ACCEPT_MAX);

  localparam logic [1:0] MSG_DIVERGE = 2'b00;
  localparam logic [1:0] MSG_CLAUSE  = 2'b01;
  localparam logic [1:0] MSG_STATUS  = 2'b10;
  localparam logic [1:0] MSG_BAD     = 2'b11;

  logic [79:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push, pop;

  logic [79:0] head;
  logic [1:0]  head_type;
  logic [63:0] head_payload;
  logic [7:0]  head_lbd;
  logic [3:0]  head_src;
  logic        unused_vc;

  logic act_drop, act_status, act_div, act_cls, bad_type;
  logic div_free, cls_free;

  logic        div_valid_q, cls_valid_q;
  logic [31:0] div_lit_q, cls_lit0_q, cls_lit1_q;
  logic [3:0]  div_src_q, cls_src_q;
  logic [7:0]  cls_lbd_q;
  logic [31:0] status_q;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        err_q;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign pkt_ready = !full && !rst;
  assign push      = pkt_valid && pkt_ready;

  assign head         = mem_q[rd_ptr_q];
  assign head_type    = head[79:78];
  assign head_payload = head[77:14];
  assign head_lbd     = head[13:6];
  assign head_src     = head[5:2];
  assign unused_vc    = ^head[1:0];

  // A slot can take a new entry when empty or when its current entry drains this cycle.
  assign div_free = !div_valid_q || div_ready;
  assign cls_free = !cls_valid_q || cls_ready;

  always_comb begin
    act_drop   = 1'b0;
    act_status = 1'b0;
    act_div    = 1'b0;
    act_cls    = 1'b0;
    if (!empty) begin
      if (head_src == MY_ID_C || head_type == MSG_BAD ||
          (head_type == MSG_CLAUSE && head_lbd > LBD_MAX_C)) begin
        act_drop = 1'b1;
      end else begin
        case (head_type)
          MSG_STATUS:  act_status = 1'b1;
          MSG_DIVERGE: act_div    = div_free;
          MSG_CLAUSE:  act_cls    = cls_free;
          default:     act_drop   = 1'b0;
        endcase
      end
    end
  end

  assign bad_type = !empty && (head_type == MSG_BAD);
  assign pop      = act_drop || act_status || act_div || act_cls;

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (act_drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pkt_data;
  end

  // Reload takes priority over drain so a slot can turn over every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_valid_q <= 1'b0;
      div_lit_q   <= '0;
      div_src_q   <= '0;
    end else if (act_div) begin
      div_valid_q <= 1'b1;
      div_lit_q   <= head_payload[31:0];
      div_src_q   <= head_src;
    end else if (div_ready) begin
      div_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cls_valid_q <= 1'b0;
      cls_lit0_q  <= '0;
      cls_lit1_q  <= '0;
      cls_lbd_q   <= '0;
      cls_src_q   <= '0;
    end else if (act_cls) begin
      cls_valid_q <= 1'b1;
      cls_lit0_q  <= head_payload[31:0];
      cls_lit1_q  <= head_payload[63:32];
      cls_lbd_q   <= head_lbd;
      cls_src_q   <= head_src;
    end else if (cls_ready) begin
      cls_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (act_status) status_q[{head_src, 1'b0} +: 2] <= head_payload[1:0];
      drop_cnt_q <= drop_cnt_d;
      if (bad_type) err_q <= 1'b1;
    end
  end

  always_comb begin
    any_sat   = 1'b0;
    any_unsat = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (status_q[2*i +: 2] == 2'b10) any_sat   = 1'b1;
      if (status_q[2*i +: 2] == 2'b11) any_unsat = 1'b1;
    end
  end

  assign div_valid    = div_valid_q;
  assign div_lit      = div_lit_q;
  assign div_src      = div_src_q;
  assign cls_valid    = cls_valid_q;
  assign cls_lit0     = cls_lit0_q;
  assign cls_lit1     = cls_lit1_q;
  assign cls_lbd      = cls_lbd_q;
  assign cls_src      = cls_src_q;
  assign status_table = status_q;
  assign drop_cnt     = drop_cnt_q;
  assign err_bad_type = err_q;

endmodule

// File: tb/tb_noc_rx_dispatch.sv
// Scoreboard bench for noc_rx_dispatch: a packet-level model queues expected outputs on
// acceptance and a negedge monitor compares every slot handshake against those queues.
module tb_noc_rx_dispatch;

  localparam logic [1:0] T_DIV = 2'b00;
  localparam logic [1:0] T_CLS = 2'b01;
  localparam logic [1:0] T_STS = 2'b10;
  localparam logic [1:0] T_BAD = 2'b11;
  localparam logic [3:0] MY_ID = 4'd0;
  localparam logic [7:0] LBD_MAX = 8'd6;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [79:0] pkt_data;
  logic        div_valid;
  logic        div_ready = 1'b0;
  logic [31:0] div_lit;
  logic [3:0]  div_src;
  logic        cls_valid;
  logic        cls_ready = 1'b0;
  logic [31:0] cls_lit0, cls_lit1;
  logic [7:0]  cls_lbd;
  logic [3:0]  cls_src;
  logic [31:0] status_table;
  logic        any_sat, any_unsat;
  logic [15:0] drop_cnt;
  logic        err_bad_type;

  noc_rx_dispatch #(.FIFO_DEPTH(FIFO_DEPTH), .MY_ID(0), .LBD_ACCEPT_MAX(6)) dut (
    .clk(clk), .rst(rst),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
    .div_valid(div_valid), .div_ready(div_ready), .div_lit(div_lit), .div_src(div_src),
    .cls_valid(cls_valid), .cls_ready(cls_ready), .cls_lit0(cls_lit0), .cls_lit1(cls_lit1),
    .cls_lbd(cls_lbd), .cls_src(cls_src),
    .status_table(status_table), .any_sat(any_sat), .any_unsat(any_unsat),
    .drop_cnt(drop_cnt), .err_bad_type(err_bad_type)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;
  logic [35:0] expDiv[$];
  logic [75:0] expCls[$];
  logic [31:0] modelTable = '0;
  int          modelDrop = 0;
  bit          modelErr = 1'b0;
  int          divSeen = 0;
  int          clsSeen = 0;
  bit          randomMode = 1'b0;
  bit          divForce = 1'b0;
  bit          clsForce = 1'b0;
  bit          divHeld = 1'b0;
  bit          clsHeld = 1'b0;
  logic [35:0] divHeldData;
  logic [75:0] clsHeldData;

  function automatic logic [79:0] mkPkt(input logic [1:0] t, input logic [31:0] l1,
                                        input logic [31:0] l0, input logic [7:0] q,
                                        input logic [3:0] src);
    logic [1:0] vc;
    vc = 2'($urandom_range(0, 3));
    return {t, l1, l0, q, src, vc};
  endfunction

  function automatic logic anyEntry(input logic [31:0] t, input logic [1:0] v);
    for (int i = 0; i < 16; i++) if (t[2*i +: 2] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name, input string msg);
    nVec++;
    nMis++;
    $display("[TB] FAIL %s: %s", name, msg);
  endtask

  // Packet-level reference: classify on acceptance and record the eventual effect.
  function automatic void modelAccept(input logic [79:0] p);
    logic [1:0] t;
    logic [3:0] src;
    logic [7:0] q;
    t = p[79:78];
    q = p[13:6];
    src = p[5:2];
    if (src == MY_ID || t == T_BAD || (t == T_CLS && q > LBD_MAX)) begin
      if (modelDrop < 65535) modelDrop++;
      if (t == T_BAD) modelErr = 1'b1;
    end else if (t == T_STS) begin
      modelTable[2*src +: 2] = p[15:14];
    end else if (t == T_DIV) begin
      expDiv.push_back({p[45:14], src});
    end else begin
      expCls.push_back({p[77:46], p[45:14], q, src});
    end
  endfunction

  always @(posedge clk) begin
    #2;
    if (randomMode) begin
      div_ready = ($urandom_range(0, 3) != 0);
      cls_ready = ($urandom_range(0, 3) != 0);
    end else begin
      div_ready = divForce;
      cls_ready = clsForce;
    end
  end

  // Monitor: acceptance feeds the model, handshakes pop and compare.
  always @(negedge clk) begin
    if (rst) begin
      expDiv.delete();
      expCls.delete();
      modelTable = '0;
      modelDrop = 0;
      modelErr = 1'b0;
      divHeld = 1'b0;
      clsHeld = 1'b0;
    end else begin
      if (pkt_valid && pkt_ready) modelAccept(pkt_data);
      if (divHeld) begin
        checkOutput("div_hold_valid", div_valid, 1);
        checkOutput("div_hold_data", {div_lit, div_src}, divHeldData);
      end
      if (clsHeld) begin
        checkOutput("cls_hold_valid", cls_valid, 1);
        checkOutput("cls_hold_data", {cls_lit1, cls_lit0, cls_lbd, cls_src}, clsHeldData);
      end
      if (div_valid && div_ready) begin
        if (expDiv.size() == 0) flagFail("div_unexpected", $sformatf("lit 0x%0h src %0d with nothing expected", div_lit, div_src));
        else checkOutput("div_data", {div_lit, div_src}, expDiv.pop_front());
        divSeen++;
      end
      if (cls_valid && cls_ready) begin
        if (expCls.size() == 0) flagFail("cls_unexpected", $sformatf("lits 0x%0h/0x%0h with nothing expected", cls_lit0, cls_lit1));
        else checkOutput("cls_data", {cls_lit1, cls_lit0, cls_lbd, cls_src}, expCls.pop_front());
        clsSeen++;
      end
      divHeld = div_valid && !div_ready;
      divHeldData = {div_lit, div_src};
      clsHeld = cls_valid && !cls_ready;
      clsHeldData = {cls_lit1, cls_lit0, cls_lbd, cls_src};
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input logic [79:0] p);
    int w;
    w = 0;
    pkt_data = p;
    pkt_valid = 1'b1;
    @(negedge clk);
    while (!pkt_ready && w < 300) begin
      w++;
      @(negedge clk);
    end
    if (!pkt_ready) flagFail("send_timeout", "pkt_ready never rose");
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
  endtask

  task automatic waitQuiet(input string tag);
    int w;
    w = 0;
    randomMode = 1'b0;
    divForce = 1'b1;
    clsForce = 1'b1;
    while ((expDiv.size() != 0 || expCls.size() != 0) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (expDiv.size() != 0 || expCls.size() != 0)
      flagFail({tag, "_drain"}, $sformatf("%0d div / %0d cls still pending", expDiv.size(), expCls.size()));
    repeat (FIFO_DEPTH + 4) @(negedge clk);
    checkOutput({tag, "_status_table"}, status_table, modelTable);
    checkOutput({tag, "_any_sat"}, any_sat, anyEntry(modelTable, 2'b10));
    checkOutput({tag, "_any_unsat"}, any_unsat, anyEntry(modelTable, 2'b11));
    checkOutput({tag, "_drop_cnt"}, drop_cnt, modelDrop);
    checkOutput({tag, "_err_bad_type"}, err_bad_type, modelErr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] snap;
    int divSnap, clsSnap;
    rst = 1'b1;
    pkt_valid = 1'b0;
    pkt_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_pkt_ready", pkt_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_pkt_ready", pkt_ready, 1);
    checkOutput("post_rst_div_valid", div_valid, 0);
    checkOutput("post_rst_cls_valid", cls_valid, 0);
    checkOutput("post_rst_div_data", {div_lit, div_src}, 0);
    checkOutput("post_rst_cls_data", {cls_lit1, cls_lit0}, 0);
    checkOutput("post_rst_cls_meta", {cls_lbd, cls_src}, 0);
    checkOutput("post_rst_status", status_table, 0);
    checkOutput("post_rst_drop", drop_cnt, 0);
    checkOutput("post_rst_err", err_bad_type, 0);
    checkOutput("post_rst_any", {any_sat, any_unsat}, 0);
    @(posedge clk);
    #1;

    $display("[TB] divergence path");
    divForce = 1'b1;
    clsForce = 1'b1;
    applyStimulus(mkPkt(T_DIV, 32'd0, 32'hFFFF_FFF9, 8'd0, 4'd2));
    @(negedge clk);
    checkOutput("div_not_before_e1", div_valid, 0);
    @(negedge clk);
    checkOutput("div_valid_e1", div_valid, 1);
    checkOutput("div_lit_m7", div_lit, 32'hFFFF_FFF9);
    checkOutput("div_src_2", div_src, 4'd2);
    @(negedge clk);
    checkOutput("div_single_cycle", div_valid, 0);
    @(posedge clk);
    #1;

    $display("[TB] back-to-back divergence");
    applyStimulus(mkPkt(T_DIV, 32'd0, 32'd11, 8'd0, 4'd4));
    applyStimulus(mkPkt(T_DIV, 32'd0, 32'd12, 8'd0, 4'd4));
    applyStimulus(mkPkt(T_DIV, 32'd0, 32'd13, 8'd0, 4'd4));
    @(negedge clk);
    checkOutput("b2b_valid_2", div_valid, 1);
    checkOutput("b2b_lit_2", div_lit, 32'd12);
    @(negedge clk);
    checkOutput("b2b_valid_3", div_valid, 1);
    checkOutput("b2b_lit_3", div_lit, 32'd13);
    @(negedge clk);
    checkOutput("b2b_done", div_valid, 0);
    @(posedge clk);
    #1;
    waitQuiet("div");

    $display("[TB] clause path and LBD filter");
    applyStimulus(mkPkt(T_CLS, 32'hFFFF_FFF7, 32'd5, 8'd6, 4'd1));
    waitQuiet("cls_lbd6");
    checkOutput("cls_lbd6_seen", clsSeen, 1);
    applyStimulus(mkPkt(T_CLS, 32'hFFFF_FFF7, 32'd5, 8'd7, 4'd1));
    waitQuiet("cls_lbd7");
    checkOutput("cls_lbd7_drop", drop_cnt, 16'd1);
    checkOutput("cls_lbd7_not_seen", clsSeen, 1);

    $display("[TB] status table");
    applyStimulus(mkPkt(T_STS, 32'd0, 32'd2, 8'd0, 4'd3));
    waitQuiet("sts_sat");
    checkOutput("sts_entry3_sat", status_table[7:6], 2'b10);
    checkOutput("sts_any_sat", {any_sat, any_unsat}, 2'b10);
    applyStimulus(mkPkt(T_STS, 32'd0, 32'd3, 8'd0, 4'd3));
    waitQuiet("sts_unsat");
    checkOutput("sts_entry3_unsat", status_table[7:6], 2'b11);
    checkOutput("sts_any_unsat", {any_sat, any_unsat}, 2'b01);
    applyStimulus(mkPkt(T_STS, 32'd0, 32'd1, 8'd0, 4'd6));
    applyStimulus(mkPkt(T_STS, 32'd0, 32'd2, 8'd0, 4'd6));
    waitQuiet("sts_lww");
    checkOutput("sts_last_write_wins", status_table[13:12], 2'b10);

    $display("[TB] loopback and bad type");
    divSnap = divSeen;
    applyStimulus(mkPkt(T_DIV, 32'd0, 32'd42, 8'd0, MY_ID));
    waitQuiet("loopback");
    checkOutput("loopback_drop", drop_cnt, 16'd2);
    checkOutput("loopback_no_div", divSeen, divSnap);
    applyStimulus(mkPkt(T_BAD, 32'd0, 32'd1, 8'd0, 4'd5));
    waitQuiet("badtype");
    checkOutput("badtype_drop", drop_cnt, 16'd3);
    checkOutput("badtype_err", err_bad_type, 1);

    $display("[TB] backpressure and ordering");
    divForce = 1'b0;
    clsForce = 1'b1;
    snap = modelTable;
    divSnap = divSeen;
    clsSnap = clsSeen;
    applyStimulus(mkPkt(T_DIV, 32'd0, 32'd100, 8'd0, 4'd7));
    applyStimulus(mkPkt(T_DIV, 32'd0, 32'd101, 8'd0, 4'd7));
    applyStimulus(mkPkt(T_STS, 32'd0, 32'd1, 8'd0, 4'd5));
    applyStimulus(mkPkt(T_CLS, 32'd201, 32'd200, 8'd2, 4'd8));
    applyStimulus(mkPkt(T_DIV, 32'd0, 32'd102, 8'd0, 4'd7));
    repeat (2) begin
      @(negedge clk);
      checkOutput("bp_pkt_ready", pkt_ready, 0);
      checkOutput("bp_div_valid", div_valid, 1);
      checkOutput("bp_div_lit", div_lit, 32'd100);
      checkOutput("bp_cls_blocked", cls_valid, 0);
      checkOutput("bp_status_unchanged", status_table, snap);
    end
    @(posedge clk);
    #1;
    waitQuiet("bp");
    checkOutput("bp_status_applied", status_table[11:10], 2'b01);
    checkOutput("bp_div_count", divSeen - divSnap, 3);
    checkOutput("bp_cls_count", clsSeen - clsSnap, 1);

    $display("[TB] randomized traffic");
    randomMode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [1:0] t;
      r = $urandom_range(0, 9);
      t = (r < 4) ? T_DIV : (r < 7) ? T_CLS : (r < 9) ? T_STS : T_BAD;
      applyStimulus(mkPkt(t, $urandom, $urandom, 8'($urandom_range(0, 10)), 4'($urandom_range(0, 15))));
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    waitQuiet("random");

    $display("[TB] reset mid-flight");
    divForce = 1'b0;
    clsForce = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(mkPkt(T_DIV, 32'd0, 32'(300 + i), 8'd0, 4'd9));
    applyStimulus(mkPkt(T_STS, 32'd0, 32'd2, 8'd0, 4'd9));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_pkt_ready", pkt_ready, 1);
    checkOutput("midrst_div_valid", div_valid, 0);
    checkOutput("midrst_cls_valid", cls_valid, 0);
    checkOutput("midrst_status", status_table, 0);
    checkOutput("midrst_drop", drop_cnt, 0);
    checkOutput("midrst_err", err_bad_type, 0);
    divSnap = divSeen;
    divForce = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("midrst_no_stale", divSeen, divSnap);
    @(posedge clk);
    #1;
    waitQuiet("midrst");

    $display("[TB] == %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
